rtc_read_sequencer: RTL
=======================

# rtc_read_sequencer

Bus-read engine for the RTC controller, the read-side counterpart of the address/data byte selector that drives the multiplexed RTC bus on writes. On a start pulse it walks the clock registers (0x21–0x26) or the timer registers (0x41–0x43). For each register it issues an address phase, then a data-read phase, on the multiplexed AD bus, and captures the returned byte. The captured set is committed atomically to output registers consumed by the display/format logic. It also raises a done pulse and a BCD-validity flag.

## Interface
Parameters:
- T_STB, 4, strobe-low width in clk cycles for each phase; legal range 1–15.
- T_GAP, 2, all-strobes-high gap in clk cycles after each strobe; legal range 1–15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- sel_tim  input  1  sampled with start. 0 selects the clock set: 0x21..0x26, 6 registers. 1 selects the timer set: 0x41..0x43, 3 registers.
- bus_in  input  8  AD bus value returned by the RTC.
- bus_out  output  8  address byte driven on the AD bus.
- bus_oe  output  1  1 = bus_out is driven onto the AD pins.
- cs_n, rd_n, wr_n, ad_n  output  1 each  RTC strobes, active-low. ad_n=0 marks an address phase.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the outputs are committed.
- bcd_err  output  1  valid with done; held until the next commit.
- seg, min, hora, dia, mes, anio  output  8 each  committed clock registers.
- seg_tim, min_tim, hora_tim  output  8 each  committed timer registers.

## Operation
- States: IDLE, A_STB, A_GAP, D_STB, D_GAP, COMMIT.
- IDLE: strobes high, bus_oe=0, busy=0.
  - start=1 latches sel_tim.
  - Index idx is set to 0.
  - Next state is A_STB.
- A_STB, T_STB cycles:
  - cs_n=0, wr_n=0, ad_n=0, bus_oe=1.
  - bus_out = base+idx, where base=0x21 if sel_tim=0, else 0x41.
- A_GAP, T_GAP cycles:
  - All strobes high.
  - bus_oe stays 1 and bus_out holds, giving address hold time.
- D_STB, T_STB cycles:
  - cs_n=0, rd_n=0, ad_n=1, bus_oe=0.
  - bus_in is captured into shadow[idx] on the last D_STB cycle.
- D_GAP, T_GAP cycles:
  - All strobes high, bus_oe=0.
  - If idx is the last index (5 for the clock set, 2 for the timer set), go to COMMIT.
  - Otherwise increment idx and go to A_STB.
- COMMIT, 1 cycle:
  - Shadow bytes are copied to the selected output group only. The other group is untouched.
  - done=1, and bcd_err is updated.
  - Next state is IDLE.
- BCD check:
  - bcd_err=1 if any captured byte in this run has a nibble greater than 9.
  - It is computed over the full 8 bits; no masking of control bits.
- start arriving while busy=1, in COMMIT, or coincident with done is ignored; it is not queued.
- rd_n and wr_n are never low in the same cycle.
- bus_oe=1 never coincides with rd_n=0.
- A single phase counter (4 bits) times both strobe and gap phases. It reloads on every state entry.

## Timing
- Reset values, asynchronous:
  - State IDLE.
  - cs_n=rd_n=wr_n=ad_n=1.
  - bus_oe=0, bus_out=0x00.
  - busy=0, done=0, bcd_err=0.
  - All nine data outputs 0x00.
- Start accepted at edge E:
  - busy=1 and A_STB outputs are active from E+1.
- Per register: 2·(T_STB+T_GAP) cycles, which is 12 at the defaults.
- done, counting from the start edge:
  - Clock set: E + 6·2·(T_STB+T_GAP) + 1, which is 73 at the defaults.
  - Timer set: E + 3·2·(T_STB+T_GAP) + 1, which is 37 at the defaults.
- busy falls in the same cycle done rises.
- Outputs change only on the COMMIT edge. Mid-run values never appear.
- Reset mid-run:
  - Strobes go high and bus_oe goes to 0 immediately, without waiting for a clock edge.
  - Shadow contents and all outputs are cleared.
  - No done pulse is produced.

## Test plan
- Clock read at defaults: model returns 0x45,0x30,0x12,0x28,0x09,0x16 for 0x21..0x26.
  - Required: done at cycle 73 after start.
  - seg=0x45, min=0x30, hora=0x12, dia=0x28, mes=0x09, anio=0x16.
  - bcd_err=0; timer outputs remain 0x00.
- Timer read, sel_tim=1: model returns 0x10,0x05,0x01.
  - Required: address sequence is 0x41, 0x42, 0x43 and done at cycle 37.
  - seg_tim=0x10, min_tim=0x05, hora_tim=0x01; clock outputs unchanged.
- BCD error: min returns 0x3A.
  - Required: bcd_err=1 with done, and min=0x3A is committed.
  - A following clean run clears bcd_err to 0.
- Protocol checker running over all runs:
  - Each strobe-low width equals T_STB and each gap equals T_GAP.
  - No rd_n/wr_n overlap, and no bus_oe with rd_n=0.
  - Repeat with T_STB=1, T_GAP=1; done is at cycle 25 for the clock set.
- Start issued at cycles 5 and 72 of a clock run is ignored: exactly one done, and 6 address phases.
- Reset asserted in the D_STB phase of register 3:
  - Strobes high and bus_oe=0 at once, outputs 0x00, no done.
  - A new start after release completes normally.

Source files
------------

// File: rtl/rtc_read_sequencer_if.sv
// Signal bundle between the RTC read sequencer, its requester and the RTC pins.
// master = requester/RTC side, slave = sequencer side.
interface rtc_read_sequencer_if;
  logic       start;
  logic       sel_tim;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       ad_n;
  logic       busy;
  logic       done;
  logic       bcd_err;
  logic [7:0] seg;
  logic [7:0] min;
  logic [7:0] hora;
  logic [7:0] dia;
  logic [7:0] mes;
  logic [7:0] anio;
  logic [7:0] seg_tim;
  logic [7:0] min_tim;
  logic [7:0] hora_tim;

  modport master (
    output start, sel_tim, bus_in,
    input  bus_out, bus_oe, cs_n, rd_n, wr_n, ad_n, busy, done, bcd_err,
    input  seg, min, hora, dia, mes, anio, seg_tim, min_tim, hora_tim
  );

  modport slave (
    input  start, sel_tim, bus_in,
    output bus_out, bus_oe, cs_n, rd_n, wr_n, ad_n, busy, done, bcd_err,
    output seg, min, hora, dia, mes, anio, seg_tim, min_tim, hora_tim
  );
endinterface

// File: rtl/rtc_read_sequencer.sv
// Reads the RTC clock (0x21..0x26) or timer (0x41..0x43) registers over the
// multiplexed AD bus and commits the captured set atomically.
module rtc_read_sequencer #(
  parameter int T_STB = 4,
  parameter int T_GAP = 2
) (
  input logic                 clk,
  input logic                 reset,
  rtc_read_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_A_STB, S_A_GAP, S_D_STB, S_D_GAP, S_COMMIT
  } state_t;

  localparam logic [3:0] STB_LD   = 4'(T_STB - 1);
  localparam logic [3:0] GAP_LD   = 4'(T_GAP - 1);
  localparam logic [7:0] CLK_BASE = 8'h21;
  localparam logic [7:0] TIM_BASE = 8'h41;

  state_t     r_state, w_next;
  logic [3:0] r_cnt, w_cnt_ld;
  logic [2:0] r_idx;
  logic       r_sel, r_acc, r_done, r_bcd_err;
  logic [7:0] r_shadow [6];
  logic [7:0] r_clk    [6];
  logic [7:0] r_tim    [3];
  logic       w_cnt_zero, w_last;
  logic [7:0] w_base;

  function automatic logic bcd_bad(input logic [7:0] b);
    return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  assign w_cnt_zero = (r_cnt == 4'd0);
  assign w_last     = r_sel ? (r_idx == 3'd2) : (r_idx == 3'd5);
  assign w_base     = r_sel ? TIM_BASE : CLK_BASE;

  // Strobes are decoded straight from state so reset releases the bus at once
  always_comb begin
    w_next      = r_state;
    w_cnt_ld    = 4'd0;
    bus.cs_n    = 1'b1;
    bus.rd_n    = 1'b1;
    bus.wr_n    = 1'b1;
    bus.ad_n    = 1'b1;
    bus.bus_oe  = 1'b0;
    bus.bus_out = 8'h00;
    case (r_state)
      S_IDLE:   if (bus.start && !r_done) w_next = S_A_STB;
      S_A_STB: begin
        bus.cs_n    = 1'b0;
        bus.wr_n    = 1'b0;
        bus.ad_n    = 1'b0;
        bus.bus_oe  = 1'b1;
        bus.bus_out = w_base + {5'd0, r_idx};
        if (w_cnt_zero) w_next = S_A_GAP;
      end
      S_A_GAP: begin
        bus.bus_oe  = 1'b1;
        bus.bus_out = w_base + {5'd0, r_idx};
        if (w_cnt_zero) w_next = S_D_STB;
      end
      S_D_STB: begin
        bus.cs_n = 1'b0;
        bus.rd_n = 1'b0;
        if (w_cnt_zero) w_next = S_D_GAP;
      end
      S_D_GAP:  if (w_cnt_zero) w_next = w_last ? S_COMMIT : S_A_STB;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    case (w_next)
      S_A_STB, S_D_STB: w_cnt_ld = STB_LD;
      S_A_GAP, S_D_GAP: w_cnt_ld = GAP_LD;
      default:          w_cnt_ld = 4'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= w_cnt_ld;
      else if (!w_cnt_zero)  r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx     <= 3'd0;
      r_sel     <= 1'b0;
      r_acc     <= 1'b0;
      r_done    <= 1'b0;
      r_bcd_err <= 1'b0;
      for (int i = 0; i < 6; i++) r_shadow[i] <= 8'h00;
      for (int i = 0; i < 6; i++) r_clk[i]    <= 8'h00;
      for (int i = 0; i < 3; i++) r_tim[i]    <= 8'h00;
    end else begin
      r_done <= (r_state == S_COMMIT);
      if (r_state == S_IDLE && w_next == S_A_STB) begin
        r_sel <= bus.sel_tim;
        r_idx <= 3'd0;
        r_acc <= 1'b0;
      end else if (r_state == S_D_GAP && w_cnt_zero && !w_last) begin
        r_idx <= r_idx + 3'd1;
      end
      // Sample the returned byte as late as possible in the read strobe
      if (r_state == S_D_STB && w_cnt_zero) begin
        r_shadow[r_idx] <= bus.bus_in;
        r_acc           <= r_acc | bcd_bad(bus.bus_in);
      end
      if (r_state == S_COMMIT) begin
        r_bcd_err <= r_acc;
        if (r_sel) for (int i = 0; i < 3; i++) r_tim[i] <= r_shadow[i];
        else       for (int i = 0; i < 6; i++) r_clk[i] <= r_shadow[i];
      end
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.bcd_err  = r_bcd_err;
  assign bus.seg      = r_clk[0];
  assign bus.min      = r_clk[1];
  assign bus.hora     = r_clk[2];
  assign bus.dia      = r_clk[3];
  assign bus.mes      = r_clk[4];
  assign bus.anio     = r_clk[5];
  assign bus.seg_tim  = r_tim[0];
  assign bus.min_tim  = r_tim[1];
  assign bus.hora_tim = r_tim[2];

endmodule
